// File: rtl/gl_cmd_pkg.sv
// Shared definitions for the GL command-list fetcher: opcodes, opcode word fields,
// FSM state encoding and the argument bus type.
package gl_cmd_pkg;

    localparam logic [7:0] OP_END         = 8'h00;
    localparam logic [7:0] OP_VERTEX      = 8'h03;
    localparam logic [7:0] OP_COLOR       = 8'h04;
    localparam logic [7:0] OP_FLUSH       = 8'h05;
    localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
    localparam logic [7:0] OP_ROTATE      = 8'h11;

    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 7;
    localparam int IMM_LSB      = 8;
    localparam int IMM_MSB      = 15;
    localparam int HAS_ARGS_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } gl_state_t;

    typedef logic [127:0] gl_args_t;

    // The count field doubles as an immediate when the has-args bit is clear.
    function automatic logic [7:0] arg_count(input logic [31:0] word);
        return word[HAS_ARGS_BIT] ? word[IMM_MSB:IMM_LSB] : 8'd0;
    endfunction

endpackage

// File: rtl/gl_cmd_fetch.sv
// Walks a command list in instruction memory and emits each command as 1..N beats of
// up to four arguments. Optional macro CMD_FETCH_BOUND_CHK_EN adds a memory range check.
module gl_cmd_fetch
    import gl_cmd_pkg::*;
#(
    parameter int MEM_WORDS = 50,
    parameter int MAX_ARGS  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  base_addr,
    output logic [31:0]  addr1,
    output logic [31:0]  addr2,
    input  logic [31:0]  read0,
    input  logic [31:0]  read1,
    input  logic [31:0]  read2,
    input  logic [31:0]  read3,
    input  logic [31:0]  read4,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_op,
    output logic [7:0]   cmd_imm,
    output logic [127:0] cmd_args,
    output logic [2:0]   cmd_arg_cnt,
    output logic         cmd_first,
    output logic         cmd_last,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [2:0]   state_dbg
);

    if (MAX_ARGS < 0 || MAX_ARGS > 255 || MEM_WORDS < 1) begin : g_bad_cfg
        $error("gl_cmd_fetch: MAX_ARGS must fit the 8-bit count field and MEM_WORDS must be >= 1");
    end

    gl_state_t   state_q, state_d;
    logic [31:0] pc_q, addr2_q;
    logic [7:0]  op_q, imm_q, n_total_q, n_rem_q;
    gl_args_t    args_q;
    logic        first_q;

    logic [7:0]  fetch_n;
    logic        fetch_end, n_over, fetch_bad;
    logic        issue, beat_last;

    assign fetch_n   = arg_count(read0);
    assign fetch_end = (read0 == 32'd0);
    assign n_over    = (32'(fetch_n) > 32'(MAX_ARGS));

`ifdef CMD_FETCH_BOUND_CHK_EN
    assign fetch_bad = n_over || ((pc_q + 32'(fetch_n)) >= 32'(MEM_WORDS));
`else
    assign fetch_bad = n_over;
`endif

    assign issue     = (state_q == ST_ISSUE);
    assign beat_last = (n_rem_q <= 8'd4);

    // Beat handshake: a beat transfers on a rising edge where cmd_valid and cmd_ready
    // are both 1; cmd_valid never drops and no cmd_* output changes until that edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_end)      state_d = ST_DONE;
                else if (fetch_bad) state_d = ST_ERR;
                else                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (cmd_ready && beat_last) state_d = ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= 32'd0;
            addr2_q   <= 32'd0;
            op_q      <= 8'd0;
            imm_q     <= 8'd0;
            n_total_q <= 8'd0;
            n_rem_q   <= 8'd0;
            args_q    <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (start && !abort) pc_q <= base_addr;
                ST_FETCH: if (!abort) begin
                    op_q      <= read0[OP_MSB:OP_LSB];
                    imm_q     <= read0[IMM_MSB:IMM_LSB];
                    n_total_q <= fetch_n;
                    n_rem_q   <= fetch_n;
                    first_q   <= 1'b1;
                    args_q    <= (fetch_n == 8'd0) ? '0 : {read4, read3, read2, read1};
                    addr2_q   <= pc_q + 32'd5;
                end
                ST_ISSUE: if (cmd_ready && !abort) begin
                    if (beat_last) begin
                        pc_q <= pc_q + 32'd1 + 32'(n_total_q);
                    end else begin
                        // Memory is already presenting the next window at addr2_q.
                        args_q  <= {read4, read3, read2, read1};
                        addr2_q <= addr2_q + 32'd4;
                        n_rem_q <= n_rem_q - 8'd4;
                        first_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr1       = pc_q;
    assign addr2       = (state_q == ST_FETCH) ? (pc_q + 32'd1) : addr2_q;
    assign cmd_valid   = issue;
    assign cmd_op      = issue ? op_q : 8'd0;
    assign cmd_imm     = issue ? imm_q : 8'd0;
    assign cmd_args    = issue ? args_q : '0;
    assign cmd_arg_cnt = !issue ? 3'd0 : (beat_last ? n_rem_q[2:0] : 3'd4);
    assign cmd_first   = issue && first_q;
    assign cmd_last    = issue && beat_last;
    assign busy        = (state_q == ST_FETCH) || issue;
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERR);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_gl_cmd_fetch.sv
// Directed bench for gl_cmd_fetch: a 50-word memory model drives the async read ports,
// and each task checks one scenario cycle by cycle at the falling edge.
module tb_gl_cmd_fetch;
    import gl_cmd_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start, abort, cmd_ready;
    logic [31:0]  base_addr;
    logic [31:0]  addr1, addr2;
    logic [31:0]  read0, read1, read2, read3, read4;
    logic         cmd_valid, cmd_first, cmd_last, busy, done, error;
    logic [7:0]   cmd_op, cmd_imm;
    logic [127:0] cmd_args;
    logic [2:0]   cmd_arg_cnt, state_dbg;

    logic [31:0]  mem [0:63];
    logic [31:0]  a_p1, a_p2, a_p3;
    logic [7:0]   exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gl_cmd_fetch #(.MEM_WORDS(50), .MAX_ARGS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
        .addr1(addr1), .addr2(addr2),
        .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .cmd_args(cmd_args), .cmd_arg_cnt(cmd_arg_cnt), .cmd_first(cmd_first),
        .cmd_last(cmd_last), .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    // Memory model: words past the 50-word array read as zero.
    assign a_p1 = addr2 + 32'd1;
    assign a_p2 = addr2 + 32'd2;
    assign a_p3 = addr2 + 32'd3;
    always_comb begin
        read0 = (addr1 < 32'd50) ? mem[addr1[5:0]] : 32'd0;
        read1 = (addr2 < 32'd50) ? mem[addr2[5:0]] : 32'd0;
        read2 = (a_p1  < 32'd50) ? mem[a_p1[5:0]]  : 32'd0;
        read3 = (a_p2  < 32'd50) ? mem[a_p2[5:0]]  : 32'd0;
        read4 = (a_p3  < 32'd50) ? mem[a_p3[5:0]]  : 32'd0;
    end

    task automatic start_cmd(input logic [31:0] base);
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; cmd_ready = 1'b1; base_addr = 32'h1234;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_valid, busy, done, error, cmd_first, cmd_last} !== 6'b0) begin
            errors++; $display("FAIL reset_status got %b want 000000",
                {cmd_valid, busy, done, error, cmd_first, cmd_last});
        end
        checks++;
        if ({addr1, addr2} !== 64'd0) begin
            errors++; $display("FAIL reset_addr got %h/%h want 0/0", addr1, addr2);
        end
        checks++;
        if ({cmd_op, cmd_imm, cmd_arg_cnt} !== 19'd0 || cmd_args !== 128'd0) begin
            errors++; $display("FAIL reset_cmd got op=%h imm=%h cnt=%0d args=%h want zeros",
                cmd_op, cmd_imm, cmd_arg_cnt, cmd_args);
        end
        rst = 1'b0; start = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL reset_idle got state=%0d want 0", state_dbg);
        end
    endtask

    task automatic test_color();
        start_cmd(32'd0);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0 || addr1 !== 32'd0 || addr2 !== 32'd1) begin
            errors++; $display("FAIL color_fetch got busy=%b valid=%b a1=%h a2=%h want 1 0 0 1",
                busy, cmd_valid, addr1, addr2);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h04 || cmd_imm !== 8'h03 || cmd_arg_cnt !== 3'd3 ||
            cmd_first !== 1'b1 || cmd_last !== 1'b1 || cmd_args[31:0] !== 32'h3F800000) begin
            errors++; $display("FAIL color_beat got v=%b op=%h imm=%h cnt=%0d f=%b l=%b a0=%h want 1 04 03 3 1 1 3f800000",
                cmd_valid, cmd_op, cmd_imm, cmd_arg_cnt, cmd_first, cmd_last, cmd_args[31:0]);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || addr1 !== 32'd4) begin
            errors++; $display("FAIL color_next_fetch got v=%b busy=%b a1=%h want 0 1 4",
                cmd_valid, busy, addr1);
        end
        cmd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL color_done got done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL color_idle got done=%b state=%0d want 0 0", done, state_dbg);
        end
    endtask

    task automatic test_rotate();
        logic [127:0] exp_args;
        cmd_ready = 1'b1;
        start_cmd(32'd10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_args = {mem[14 + 4*b], mem[13 + 4*b], mem[12 + 4*b], mem[11 + 4*b]};
            checks++;
            if (cmd_valid !== 1'b1 || cmd_op !== 8'h11 || cmd_arg_cnt !== 3'd4 ||
                cmd_first !== (b == 0) || cmd_last !== (b == 3) || cmd_args !== exp_args) begin
                errors++; $display("FAIL rotate_beat%0d got v=%b op=%h cnt=%0d f=%b l=%b args=%h want args=%h",
                    b, cmd_valid, cmd_op, cmd_arg_cnt, cmd_first, cmd_last, cmd_args, exp_args);
            end
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || addr1 !== 32'd27) begin
            errors++; $display("FAIL rotate_next_pc got v=%b a1=%0d want 0 27", cmd_valid, addr1);
        end
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        cmd_ready = 1'b0;
        start_cmd(32'd30);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_op !== 8'h10 || cmd_imm !== 8'h01 || cmd_arg_cnt !== 3'd0 ||
                cmd_args !== 128'd0 || cmd_first !== 1'b1 || cmd_last !== 1'b1) begin
                errors++; $display("FAIL stall_cyc%0d got v=%b op=%h imm=%h cnt=%0d args=%h f=%b l=%b want 1 10 01 0 0 1 1",
                    k, cmd_valid, cmd_op, cmd_imm, cmd_arg_cnt, cmd_args, cmd_first, cmd_last);
            end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || addr1 !== 32'd31) begin
            errors++; $display("FAIL stall_release got v=%b a1=%0d want 0 31", cmd_valid, addr1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequence();
        int done_cnt = 0;
        logic [7:0] exp_op;
        exp_q.delete();
        exp_q.push_back(OP_COLOR);
        exp_q.push_back(OP_VERTEX);
        exp_q.push_back(OP_FLUSH);
        cmd_ready = 1'b1;
        start_cmd(32'd35);
        for (int c = 0; c < 20; c++) begin
            if (cmd_valid && cmd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL seq_extra got op=%h want no beat", cmd_op);
                end else begin
                    exp_op = exp_q.pop_front();
                    if (cmd_op !== exp_op) begin
                        errors++; $display("FAIL seq_op got %h want %h", cmd_op, exp_op);
                    end
                end
            end
            if (done) done_cnt++;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL seq_end got left=%0d done=%0d busy=%b want 0 1 0",
                exp_q.size(), done_cnt, busy);
        end
    endtask

    task automatic test_error();
        start_cmd(32'd45);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL err_enter got err=%b v=%b busy=%b want 1 0 0", error, cmd_valid, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || state_dbg !== 3'd4) begin
            errors++; $display("FAIL err_sticky got err=%b state=%0d want 1 4", error, state_dbg);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (error !== 1'b0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL err_abort got err=%b state=%0d want 0 0", error, state_dbg);
        end
    endtask

    task automatic test_bound();
        start_cmd(32'd48);
        @(negedge clk);
`ifdef CMD_FETCH_BOUND_CHK_EN
        checks++;
        if (error !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL bound_err got err=%b v=%b want 1 0", error, cmd_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`else
        checks++;
        if (cmd_valid !== 1'b1 || cmd_arg_cnt !== 3'd3 || cmd_args[63:0] !== 64'h0000000000000011) begin
            errors++; $display("FAIL bound_nochk got v=%b cnt=%0d args=%h want 1 3 ..11",
                cmd_valid, cmd_arg_cnt, cmd_args[63:0]);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if (addr1 !== 32'd52) begin
            errors++; $display("FAIL bound_next_pc got %0d want 52", addr1);
        end
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_abort();
        int stray = 0;
        cmd_ready = 1'b1;
        start_cmd(32'd10);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_first !== 1'b0) begin
            errors++; $display("FAIL abort_beat2 got v=%b f=%b want 1 0", cmd_valid, cmd_first);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL abort_idle got v=%b busy=%b state=%0d want 0 0 0",
                cmd_valid, busy, state_dbg);
        end
        for (int c = 0; c < 8; c++) begin
            if (done || cmd_valid) stray++;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL abort_quiet got %0d stray cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        start_cmd(32'd10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || addr1 !== 32'd0 || addr2 !== 32'd0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL rst_mid got v=%b busy=%b a1=%h a2=%h state=%0d want 0 0 0 0 0",
                cmd_valid, busy, addr1, addr2, state_dbg);
        end
        for (int c = 0; c < 8; c++) begin
            if (done || cmd_valid) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rst_mid_quiet got %0d stray cycles want 0", stray);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h80000304; mem[1] = 32'h3F800000;
        for (int i = 11; i <= 26; i++) mem[i] = 32'hA0000000 + 32'(i);
        mem[10] = 32'h80001011;
        mem[30] = 32'h00000110;
        mem[32] = 32'hDEAD0001; mem[33] = 32'hDEAD0002; mem[34] = 32'hDEAD0003;
        mem[35] = 32'h80000304; mem[36] = 32'h3F800000; mem[37] = 32'h3F000000; mem[38] = 32'h3E800000;
        mem[39] = 32'h80000303; mem[40] = 32'h00000001; mem[41] = 32'h00000002; mem[42] = 32'h00000003;
        mem[43] = 32'h00000005;
        mem[45] = 32'h80001100;
        mem[48] = 32'h80000303; mem[49] = 32'h00000011;

        test_reset();
        test_color();
        test_rotate();
        test_stall();
        test_sequence();
        test_error();
        test_bound();
        test_abort();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gl_cmd_fetch.md
GL_CMD_FETCH -- requirements
Module: gl_cmd_fetch

Interface
REQ-001 Parameter MEM_WORDS, default 50: instruction memory depth in words.
REQ-002 Parameter MAX_ARGS, default 16: largest legal argument count.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin a command list at base_addr; ignored unless IDLE.
REQ-006 abort  in  1  synchronous abort to IDLE.
REQ-007 base_addr  in  32  word address of the first opcode.
REQ-008 addr1  out  32  opcode read address (async memory port 0).
REQ-009 addr2  out  32  argument window base (ports 1-4 read addr2..addr2+3).
REQ-010 read0..read4  in  32 each  async read data, valid in the same cycle.
REQ-011 cmd_valid / cmd_ready  out / in  1  beat handshake; transfer when both are 1.
REQ-012 cmd_op, cmd_imm  out  8 each  opcode word bits[7:0] and [15:8].
REQ-013 cmd_args  out  128  args; arg0 in [31:0] up to arg3 in [127:96].
REQ-014 cmd_arg_cnt  out  3  valid args this beat (0-4).
REQ-015 cmd_first, cmd_last  out  1 each  beat position within the command.
REQ-016 busy, done, error  out  1 each  status; done is a one-cycle pulse.

Function
REQ-017 Opcode word format: bit31=1 means bits[15:8] hold the argument count N; bit31=0 means no args and bits[15:8] form an immediate.
REQ-018 Word 0x00000000 SHALL be END; opcode 0x05 (FLUSH) SHALL be forwarded like any other command.
REQ-019 States are IDLE, FETCH, ISSUE, DONE and ERR.
- IDLE->FETCH: on start; pc<=base_addr.
- ERR: left only by rst or abort.
REQ-020 In FETCH: addr1=pc and addr2=pc+1.
- Latch read0 fields, read1..read4 and beat count; addr2<=pc+5.
- Next: ISSUE, or DONE if the word is END, or ERR if N>MAX_ARGS.
REQ-021 Beats=max(1,ceil(N/4)).
- cmd_arg_cnt=4 except on the last beat, which carries N-4*(beats-1).
- N=0 gives one beat with cnt 0 and cmd_args=0.
REQ-022 In ISSUE, cmd_valid=1 and every cmd_* output SHALL be held stable until the handshake.
REQ-023 On a non-last handshake:
- Capture read1..read4 at the current addr2.
- addr2+=4; cmd_first<=0.
- cmd_valid stays 1, giving back-to-back beats with no bubble.
REQ-024 On the last handshake: pc<=pc+1+N; go to FETCH.
- Exactly one idle cycle between commands.
REQ-025 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-026 busy=1 in FETCH and ISSUE.
REQ-027 error=1 in ERR, and cmd_valid=0 there.
REQ-028 All address arithmetic is 32-bit and wraps modulo 2^32.
REQ-029 abort in any state: IDLE next cycle, cmd_valid=0, no done pulse.
- abort wins over a simultaneous start or handshake.

Reset
REQ-030 rst SHALL force the following, overriding every other input:
- state IDLE, pc=0, addr1=addr2=0.
- All cmd_* outputs 0.
- busy=done=error=0.
REQ-031 rst asserted mid-command SHALL discard the command; no partial completion is signalled.

Configuration
REQ-032 Macro CMD_FETCH_BOUND_CHK_EN.
- Defined: FETCH enters ERR when pc+N >= MEM_WORDS, and no beat is issued.
- Undefined: no range check; reads past the end return whatever the memory supplies.

Structure
REQ-033 A shared package gl_cmd_pkg SHALL hold:
- Opcode constants: END=0x00, COLOR=0x04, VERTEX=0x03, MATRIX_MODE=0x10, ROTATE=0x11, FLUSH=0x05.
- Opcode field bit positions, the state enum, and the 128-bit args typedef.
REQ-034 No sub-module; the design is a single module.

Verification
REQ-035 Word 0x80000304 with args 0x3F800000, 0, 0 -> one beat: op=0x04, cnt=3, first=last=1, args[31:0]=0x3F800000.
REQ-036 Word 0x80001011 plus 16 args with cmd_ready tied high -> 4 consecutive beats with cnt 4,4,4,4; next FETCH at pc+17.
REQ-037 Word 0x00000110 -> one beat: op=0x10, imm=0x01, cnt=0.
- With cmd_ready held low for 5 cycles, the outputs are stable throughout.
REQ-038 Color, Vertex, 0x00000005, then 0x0 -> three commands in order, then done pulses once and busy falls.
REQ-039 Word 0x80001100 (N=17) -> ERR with error=1.
- With the macro defined, 0x80000303 at pc=48 also gives ERR.
REQ-040 Assert abort during beat 2 of a rotate -> IDLE next cycle, cmd_valid=0, done never pulses.
